// File: rtl/scan_mux.sv
// Registered multi-channel INPUTS-to-1 selector with a direct-select mode and
// a built-in scan sequencer (programmable dwell, one-shot or continuous sweep).
module scan_mux #(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 1,
    parameter int DWELL_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          nG,
    input  logic [CHANNELS*INPUTS-1:0]   D,
    input  logic [SEL_W-1:0]             SEL,
    input  logic                         MODE,
    input  logic                         SCAN_CONT,
    input  logic                         START,
    output logic [CHANNELS-1:0]          Y,
    output logic [SEL_W-1:0]             SEL_OUT,
    output logic                         STROBE,
    output logic                         BUSY,
    output logic                         DONE
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(INPUTS - 1);

    logic [0:0]          state;
    logic [SEL_W-1:0]    idx;
    logic [DWELL_W-1:0]  cnt;
    logic [CHANNELS-1:0] direct_val;
    logic [CHANNELS-1:0] scan_val;

    // Select s picks bit INPUTS-1-s; with INPUTS a power of two that is ~s.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [INPUTS-1:0] bank;
        assign bank          = D[c*INPUTS +: INPUTS];
        assign direct_val[c] = ~nG[c] & bank[~SEL];
        assign scan_val[c]   = ~nG[c] & bank[~idx];
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            Y       <= '0;
            SEL_OUT <= '0;
            STROBE  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else if (!MODE) begin
            // Direct mode also aborts any scan in flight, without DONE.
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            Y       <= direct_val;
            SEL_OUT <= SEL;
            STROBE  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            STROBE <= 1'b0;
            DONE   <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= SCAN;
                        idx   <= '0;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                SCAN: begin
                    Y       <= scan_val;
                    SEL_OUT <= idx;
                    STROBE  <= (cnt == '0);
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (idx != IDX_LAST) begin
                            idx <= idx + 1'b1;
                        end else if (SCAN_CONT) begin
                            idx <= '0;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: two instances (dwell 1 and dwell 3) share
// stimulus; directed vectors, corner-case sequences and a randomized phase.
module tb_scan_mux;

    localparam int CH = 2;
    localparam int IN = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, mode, cont, start;
    logic [CH-1:0]     ng;
    logic [CH*IN-1:0]  d;
    logic [SW-1:0]     sel;

    logic [CH-1:0] y_a, y_b;
    logic [SW-1:0] sel_a, sel_b;
    logic          str_a, str_b, busy_a, busy_b, done_a, done_b;

    scan_mux #(.CHANNELS(CH), .INPUTS(IN), .SEL_W(SW), .DWELL(1), .DWELL_W(4)) u_d1 (
        .clk(clk), .rst(rst), .nG(ng), .D(d), .SEL(sel), .MODE(mode),
        .SCAN_CONT(cont), .START(start), .Y(y_a), .SEL_OUT(sel_a),
        .STROBE(str_a), .BUSY(busy_a), .DONE(done_a));

    scan_mux #(.CHANNELS(CH), .INPUTS(IN), .SEL_W(SW), .DWELL(3), .DWELL_W(4)) u_d3 (
        .clk(clk), .rst(rst), .nG(ng), .D(d), .SEL(sel), .MODE(mode),
        .SCAN_CONT(cont), .START(start), .Y(y_b), .SEL_OUT(sel_b),
        .STROBE(str_b), .BUSY(busy_b), .DONE(done_b));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a scan is a position 0..IN*dwell-1 within the sweep.
    int            dw[2] = '{1, 3};
    bit            m_act[2];
    int            m_pos[2];
    logic [CH-1:0] m_y[2];
    int            m_sel[2];
    bit            m_str[2], m_busy[2], m_done[2];

    function automatic logic [CH-1:0] ref_mux(int s);
        logic [CH-1:0]    r;
        logic [CH*IN-1:0] t;
        for (int c = 0; c < CH; c++) begin
            t    = d >> (c*IN + IN - 1 - s);
            r[c] = ng[c] ? 1'b0 : t[0];
        end
        return r;
    endfunction

    task automatic model_step(input int u);
        if (rst) begin
            m_act[u] = 0; m_pos[u] = 0; m_y[u] = '0; m_sel[u] = 0;
            m_str[u] = 0; m_busy[u] = 0; m_done[u] = 0;
        end else if (!mode) begin
            m_act[u] = 0; m_y[u] = ref_mux(int'(sel)); m_sel[u] = int'(sel);
            m_str[u] = 0; m_busy[u] = 0; m_done[u] = 0;
        end else if (!m_act[u]) begin
            m_str[u] = 0; m_done[u] = 0;
            if (start) begin
                m_act[u] = 1; m_pos[u] = 0; m_busy[u] = 1;
            end
        end else begin
            m_sel[u]  = m_pos[u] / dw[u];
            m_y[u]    = ref_mux(m_sel[u]);
            m_str[u]  = (m_pos[u] % dw[u]) == 0;
            m_done[u] = 0;
            m_pos[u]++;
            if (m_pos[u] == IN * dw[u]) begin
                m_pos[u] = 0;
                if (!cont) begin
                    m_act[u] = 0; m_busy[u] = 0; m_done[u] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model();
        check("rand_y_d1",    int'(y_a),    int'(m_y[0]));
        check("rand_sel_d1",  int'(sel_a),  m_sel[0]);
        check("rand_str_d1",  int'(str_a),  int'(m_str[0]));
        check("rand_busy_d1", int'(busy_a), int'(m_busy[0]));
        check("rand_done_d1", int'(done_a), int'(m_done[0]));
        check("rand_y_d3",    int'(y_b),    int'(m_y[1]));
        check("rand_sel_d3",  int'(sel_b),  m_sel[1]);
        check("rand_str_d3",  int'(str_b),  int'(m_str[1]));
        check("rand_busy_d3", int'(busy_b), int'(m_busy[1]));
        check("rand_done_d3", int'(done_b), int'(m_done[1]));
    endtask

    task automatic check_zero(input string name);
        check({name, "_y"},    int'(y_a),    0);
        check({name, "_sel"},  int'(sel_a),  0);
        check({name, "_str"},  int'(str_a),  0);
        check({name, "_busy"}, int'(busy_a), 0);
        check({name, "_done"}, int'(done_a), 0);
    endtask

    typedef struct {
        logic [CH-1:0]    ng;
        logic [CH*IN-1:0] d;
        logic [SW-1:0]    sel;
        logic             start;
        logic [CH-1:0]    exp_y;
        logic [SW-1:0]    exp_sel;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{ng: 2'b00, d: 8'b0001_1000, sel: 2'd0, start: 1'b0, exp_y: 2'b01, exp_sel: 2'd0};
        vecs[1] = '{ng: 2'b00, d: 8'b0001_1000, sel: 2'd3, start: 1'b0, exp_y: 2'b10, exp_sel: 2'd3};
        vecs[2] = '{ng: 2'b11, d: 8'b0001_1000, sel: 2'd3, start: 1'b0, exp_y: 2'b00, exp_sel: 2'd3};
        vecs[3] = '{ng: 2'b00, d: 8'b0100_0100, sel: 2'd1, start: 1'b0, exp_y: 2'b11, exp_sel: 2'd1};
        vecs[4] = '{ng: 2'b10, d: 8'b0010_0010, sel: 2'd2, start: 1'b0, exp_y: 2'b01, exp_sel: 2'd2};
        vecs[5] = '{ng: 2'b00, d: 8'b0010_0010, sel: 2'd2, start: 1'b1, exp_y: 2'b11, exp_sel: 2'd2};

        rst = 1'b1; mode = 1'b0; cont = 1'b0; start = 1'b0;
        ng = '0; d = '0; sel = '0;
        tick();
        check_zero("reset");

        // Reset in the middle of a continuous scan, then idle with START low.
        rst = 1'b0; mode = 1'b1; cont = 1'b1; start = 1'b1; d = 8'b1111_1111;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre_rst_busy", int'(busy_a), 1);
        rst = 1'b1;
        tick();
        check_zero("midscan_rst");
        rst = 1'b0;
        repeat (2) tick();
        check_zero("post_rst_idle");

        // Direct-mode vector table, both instances.
        mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ng = vecs[i].ng; d = vecs[i].d; sel = vecs[i].sel; start = vecs[i].start;
            tick();
            check($sformatf("dir%0d_y_d1", i),  int'(y_a),   int'(vecs[i].exp_y));
            check($sformatf("dir%0d_y_d3", i),  int'(y_b),   int'(vecs[i].exp_y));
            check($sformatf("dir%0d_sel", i),   int'(sel_a), int'(vecs[i].exp_sel));
            check($sformatf("dir%0d_flags", i), int'({str_a, busy_a, done_a, busy_b}), 0);
        end

        // One-shot scan, dwell 1: D_0=1010 gives Y[0] = 1,0,1,0.
        rst = 1'b1; start = 1'b0; tick(); rst = 1'b0;
        mode = 1'b1; cont = 1'b0; ng = 2'b00; d = 8'b0000_1010; start = 1'b1;
        tick();
        check("os_busy_start", int'(busy_a), 1);
        check("os_str_start",  int'(str_a),  0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("os%0d_y", i),    int'(y_a),    (i % 2 == 0) ? 1 : 0);
            check($sformatf("os%0d_sel", i),  int'(sel_a),  i);
            check($sformatf("os%0d_str", i),  int'(str_a),  1);
            check($sformatf("os%0d_busy", i), int'(busy_a), (i != 3) ? 1 : 0);
            check($sformatf("os%0d_done", i), int'(done_a), (i == 3) ? 1 : 0);
        end
        tick();
        check("os_after_done", int'(done_a), 0);
        check("os_after_str",  int'(str_a),  0);
        check("os_after_y",    int'(y_a),    0);
        check("os_after_sel",  int'(sel_a),  3);

        // Dwell 3, continuous; SCAN_CONT cleared mid third sweep.
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; cont = 1'b1; d = 8'b0000_1010; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 36; k++) begin
            if (k == 28) cont = 1'b0;
            tick();
            check($sformatf("dw%0d_sel", k),  int'(sel_b),  (k / 3) % 4);
            check($sformatf("dw%0d_str", k),  int'(str_b),  (k % 3 == 0) ? 1 : 0);
            check($sformatf("dw%0d_y", k),    int'(y_b),    (((k / 3) % 4) % 2 == 0) ? 1 : 0);
            check($sformatf("dw%0d_done", k), int'(done_b), (k == 35) ? 1 : 0);
            check($sformatf("dw%0d_busy", k), int'(busy_b), (k != 35) ? 1 : 0);
        end
        tick();
        check("dw_end_done", int'(done_b), 0);
        check("dw_end_sel",  int'(sel_b),  3);

        // START held during scan is ignored; MODE drop at idx1 aborts.
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; cont = 1'b0; d = 8'b0000_1010; start = 1'b1; sel = 2'd0;
        tick();
        tick();
        check("hold_sel0", int'(sel_a), 0);
        tick();
        check("hold_sel1",  int'(sel_a),  1);
        check("hold_busy1", int'(busy_a), 1);
        mode = 1'b0;
        tick();
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        check("abort_y",    int'(y_a),    1);
        check("abort_sel",  int'(sel_a),  0);
        mode = 1'b1; start = 1'b0; sel = 2'd2;
        tick();
        check("abort_idle_busy", int'(busy_a), 0);
        check("abort_idle_sel",  int'(sel_a),  0);

        // Channel 1 disabled while idx2 is showing.
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; cont = 1'b0; d = 8'hFF; ng = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("ng_idx2_y", int'(y_a), 3);
        ng = 2'b10;
        tick();
        check("ng_idx3_y",    int'(y_a),    1);
        check("ng_idx3_done", int'(done_a), 1);
        tick();
        check("ng_hold_y", int'(y_a), 1);

        // Randomized phase against the reference model.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 0; n < 800; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            mode  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) cont = ~cont;
            start = ($urandom_range(0, 3) == 0);
            ng    = ($urandom_range(0, 3) == 0) ? CH'($urandom()) : '0;
            d     = (CH*IN)'($urandom());
            sel   = SW'($urandom());
            tick();
            cmp_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered successor to the dual 4-input selector: CHANNELS independent INPUTS-to-1 multiplexers share one select.
- Each channel has an active-low enable. A disabled channel forces its output low.
- Two modes:
  - Direct mode: select driven by the SEL input.
  - Scan mode: an internal sequencer steps the select through every input, with programmable dwell, one-shot or continuous, and strobe/busy/done handshake.
- Used for time-multiplexed readout of input banks (keypads, status lines) in the 74-series logic library.

Parameters:
- CHANNELS, 2, number of independent mux channels (>=1)
- INPUTS, 4, data inputs per channel (power of two, >=2)
- SEL_W, 2, select width = log2(INPUTS)
- DWELL, 1, clock cycles spent on each select position in scan mode (>=1)
- DWELL_W, 4, dwell counter width (2^DWELL_W >= DWELL)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- nG  in  CHANNELS  per-channel enable, active-low
- D  in  CHANNELS*INPUTS  flattened data; channel c = D[c*INPUTS +: INPUTS]
- SEL  in  SEL_W  external select (direct mode)
- MODE  in  1  0 = direct, 1 = scan
- SCAN_CONT  in  1  1 = continuous scan, 0 = one-shot sweep
- START  in  1  scan start request (level-sampled in IDLE)
- Y  out  CHANNELS  registered mux outputs
- SEL_OUT  out  SEL_W  select index that produced current Y
- STROBE  out  1  one-cycle pulse: Y holds first sample of a new scan index
- BUSY  out  1  scan in progress
- DONE  out  1  one-cycle pulse at end of one-shot sweep

Behaviour:
- Reset (rst=1 at an edge): Y=0, SEL_OUT=0, STROBE=0, BUSY=0, DONE=0, state=IDLE, idx=0, cnt=0. Reset overrides all inputs, including mid-scan.
- Bit order is decided: select value s picks channel bit D_c[INPUTS-1-s]. So s=0 selects the MSB.
- Channel function: mux_c(s) = nG[c] ? 0 : D_c[INPUTS-1-s].
- Direct mode (MODE=0):
  - Every edge: Y[c] <= mux_c(SEL), SEL_OUT <= SEL.
  - Latency 1 cycle. STROBE=0, BUSY=0, DONE=0.
  - START is ignored.
- Scan mode (MODE=1), FSM states IDLE and SCAN:
  - IDLE:
    - Y and SEL_OUT hold.
    - If START=1: state<=SCAN, idx<=0, cnt<=0, BUSY<=1.
  - SCAN, every edge:
    - Y[c] <= mux_c(idx); D is live, not latched at START.
    - SEL_OUT <= idx.
    - STROBE <= (cnt==0).
    - If cnt != DWELL-1: cnt<=cnt+1.
    - Else: cnt<=0.
      - If idx != INPUTS-1: idx<=idx+1.
      - Else if SCAN_CONT=1: idx<=0 (wrap).
      - Else: state<=IDLE, BUSY<=0, DONE<=1.
  - DONE is high for exactly one cycle, then 0. STROBE is likewise one cycle per index.
  - SCAN_CONT is evaluated live at each sweep end. Clearing it mid-sweep ends the scan after the current sweep completes.
  - START while in SCAN is ignored (no restart).
  - nG changes mid-scan take effect on the next sample.
- Mode change while BUSY (MODE 1->0):
  - Abort at that edge: state<=IDLE, BUSY<=0, no DONE.
  - Direct-mode update applies at the same edge.
- One-shot timing, INPUTS=4, DWELL=1, START sampled at edge t:
  - Edges t+1..t+4 load idx 0..3.
  - STROBE high in each of the 4 following cycles.
  - BUSY high cycles t..t+3.
  - DONE high the cycle after edge t+4. Y then holds the idx3 value.
- Scan duration = INPUTS*DWELL cycles per sweep.

Test Plan:
- Reset: drive rst=1 mid continuous scan → next cycle Y=0, SEL_OUT=0, BUSY=0, STROBE=0, DONE=0. With rst=0 and START=0, outputs stay at 0.
- Direct mode, CHANNELS=2, INPUTS=4, D_0=4'b1000, D_1=4'b0001, nG=2'b00:
  - SEL=0 → one cycle later Y=2'b01.
  - SEL=3 → Y=2'b10.
  - With nG=2'b11 → Y=2'b00.
- One-shot scan, DWELL=1, D_0=4'b1010, SCAN_CONT=0, START pulse:
  - Y[0] sequence 1,0,1,0; SEL_OUT 0,1,2,3.
  - STROBE high 4 cycles, BUSY high 4 cycles.
  - DONE single pulse; state returns to IDLE with Y[0]=0 held.
- Dwell and continuous, DWELL=3, SCAN_CONT=1:
  - Each SEL_OUT value persists 3 cycles.
  - STROBE only on the first of each 3.
  - Idx wraps 3→0 with no DONE.
  - Clearing SCAN_CONT mid-sweep → sweep completes to idx3, then one DONE.
- Abort and ignored start:
  - START held high during SCAN → no restart.
  - MODE→0 at idx1 → BUSY=0 next cycle, no DONE, Y follows SEL.
- Per-channel disable mid-scan: set nG[1]=1 at idx2 → Y[1]=0 from the next sample, Y[0] unaffected.
